// File: rtl/byte_memory_unit_pkg.sv
// ---------------------------------------------------------------------------
// byte_memory_unit_pkg
// Shared definitions for the byte-addressable memory unit:
//   - access size encodings carried on req_size
//   - FSM state type used by the top-level controller
//   - access_error(): flags misaligned or reserved-size requests
// ---------------------------------------------------------------------------
package byte_memory_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // A request is erroneous when it uses the reserved size or when a
    // half/word access is not naturally aligned. Keeping every legal access
    // aligned also guarantees that addr+k never crosses a word boundary.
    function automatic logic access_error(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr_lo[0];
            SIZE_WORD: err = (addr_lo != 2'b00);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/byte_memory_array.sv
// ---------------------------------------------------------------------------
// byte_memory_array
// Byte storage organised as four byte lanes of 2**(ADDR_WIDTH-2) entries.
// Lane 0 holds the byte at word offset 0, which is the most significant byte
// of a big-endian word. Store data arrives right-aligned and is steered onto
// the lanes with a 4-bit byte enable; load data is read as a whole word and
// steered back down to a right-aligned, unextended value.
//
// Ports:
//   clk        - clock, writes happen on its rising edge
//   wr_en      - commit a store this cycle (already qualified for errors)
//   size       - access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   addr       - byte address of the access
//   wdata      - right-aligned store data
//   rdata_raw  - right-aligned load data, upper bits zero (combinational)
// ---------------------------------------------------------------------------
module byte_memory_array
    import byte_memory_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata_raw
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            offset;
    logic [3:0]            byte_en;
    logic [31:0]           lane_wdata;
    logic [31:0]           rdata_word;

    assign word_idx = addr[ADDR_WIDTH-1:2];
    assign offset   = addr[1:0];

    // byte_en[3] selects lane 0 (bits 31:24). Replicating the source byte or
    // half across the word lets the enable alone pick the destination lane.
    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = 32'h0;
        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b1000 >> offset;
                lane_wdata = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = offset[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                byte_en    = 4'b1111;
                lane_wdata = wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                lane_wdata = 32'h0;
            end
        endcase
    end

    // One storage array per lane; contents are intentionally never reset.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_q [WORDS];

        always_ff @(posedge clk) begin
            if (wr_en && byte_en[3-l]) begin
                lane_q[word_idx] <= lane_wdata[31-8*l -: 8];
            end
        end

        assign rdata_word[31-8*l -: 8] = lane_q[word_idx];
    end

    // Pull the addressed byte/half down to bit 0.
    always_comb begin
        rdata_raw = 32'h0;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    rdata_raw = {24'h0, rdata_word[31:24]};
                    2'd1:    rdata_raw = {24'h0, rdata_word[23:16]};
                    2'd2:    rdata_raw = {24'h0, rdata_word[15:8]};
                    default: rdata_raw = {24'h0, rdata_word[7:0]};
                endcase
            end
            SIZE_HALF: begin
                rdata_raw = offset[1] ? {16'h0, rdata_word[15:0]}
                                      : {16'h0, rdata_word[31:16]};
            end
            SIZE_WORD: rdata_raw = rdata_word;
            default:   rdata_raw = 32'h0;
        endcase
    end

endmodule

// File: rtl/byte_memory_unit.sv
// ---------------------------------------------------------------------------
// byte_memory_unit
// Single-outstanding-request, big-endian byte memory with a fixed access
// latency. A request is accepted in IDLE, waits LATENCY cycles in WAIT, is
// committed to the array on the last WAIT cycle, and its response is held in
// RESP until the consumer takes it.
//
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   req_valid/ready    - request handshake (ready only in IDLE)
//   req_write          - 1 = store, 0 = load
//   req_size           - 00 byte, 01 half, 10 word, 11 reserved
//   req_signed         - sign-extend byte/half loads
//   req_addr           - byte address
//   req_wdata          - right-aligned store data
//   resp_valid/ready   - response handshake
//   resp_rdata         - right-aligned, extended load data (0 for stores/errors)
//   resp_error         - misaligned or reserved-size request
// ---------------------------------------------------------------------------
module byte_memory_unit
    import byte_memory_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t                state_q,      state_d;
    logic [3:0]            count_q,      count_d;
    logic                  write_q,      write_d;
    logic [1:0]            size_q,       size_d;
    logic                  signed_q,     signed_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [31:0]           wdata_q,      wdata_d;
    logic                  req_ready_q,  req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;

    logic        commit;
    logic        commit_err;
    logic        mem_we;
    logic [31:0] rdata_raw;
    logic [31:0] load_data;

    // The access is performed on the final WAIT cycle; a reset before then
    // simply abandons it, so no partial write can ever happen.
    assign commit     = (state_q == WAIT) && (count_q == 4'd0);
    assign commit_err = access_error(size_q, addr_q[1:0]);
    assign mem_we     = commit && write_q && !commit_err;

    byte_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk       (clk),
        .wr_en     (mem_we),
        .size      (size_q),
        .addr      (addr_q),
        .wdata     (wdata_q),
        .rdata_raw (rdata_raw)
    );

    // Extension of the raw load value; word loads pass through unchanged.
    always_comb begin
        load_data = rdata_raw;
        if (signed_q) begin
            case (size_q)
                SIZE_BYTE: load_data = {{24{rdata_raw[7]}}, rdata_raw[7:0]};
                SIZE_HALF: load_data = {{16{rdata_raw[15]}}, rdata_raw[15:0]};
                default:   load_data = rdata_raw;
            endcase
        end
    end

    // Next-state logic. All outputs are computed here and registered, so
    // they stay stable for as long as the FSM sits in a state.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    count_d     = COUNT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (count_q == 4'd0) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = commit_err;
                    resp_rdata_d = (commit_err || write_q) ? 32'h0 : load_data;
                    state_d      = RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                // req_ready only rises on the following cycle, so a new
                // request can never be taken on the retiring edge.
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_error_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'h0;
                resp_error_d = 1'b0;
                req_ready_d  = 1'b1;
                count_d      = 4'd0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            write_q      <= 1'b0;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_byte_memory_unit.sv
// ---------------------------------------------------------------------------
// tb_byte_memory_unit
// Directed, table-driven bench for byte_memory_unit with LATENCY = 3.
// ---------------------------------------------------------------------------
module tb_byte_memory_unit;

    localparam int ADDR_WIDTH = 12;
    localparam int LATENCY    = 3;
    localparam int MAX_WAIT   = 20;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_error;

    typedef struct {
        string                 name;
        logic                  write;
        logic [1:0]            size;
        logic                  sgn;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [31:0]           exp_rdata;
        logic                  exp_error;
    } vec_t;

    vec_t vecs[$];
    int   check_count = 0;
    int   pass_count  = 0;

    byte_memory_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic write, input logic [1:0] size,
                          input logic sgn, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_error);
        vec_t v;
        v.name      = name;
        v.write     = write;
        v.size      = size;
        v.sgn       = sgn;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_error = exp_error;
        vecs.push_back(v);
    endtask

    // Presents one request for a single edge, then waits (bounded) for the
    // response, returning how many cycles after the accept edge it appeared.
    task automatic issueAndWait(input vec_t v, output int cycles);
        @(posedge clk);
        #1;
        checkOutput({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        req_write  = v.write;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cycles    = 0;
        while (resp_valid !== 1'b1 && cycles < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int cycles;
        issueAndWait(v, cycles);
        checkOutput({v.name, " latency"}, 32'(cycles), 32'(LATENCY));
        checkOutput({v.name, " rdata"}, resp_rdata, v.exp_rdata);
        checkOutput({v.name, " error"}, 32'(resp_error), 32'(v.exp_error));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput({v.name, " retired"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int   cycles;
        vec_t v;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = SZ_W;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        #3;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset resp_error", 32'(resp_error), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //     name              wr    size  sgn   addr     wdata          exp_rdata      err
        addVec("st_w_010",       1'b1, SZ_W, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
        addVec("ld_w_010",       1'b0, SZ_W, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        addVec("ld_bu_010",      1'b0, SZ_B, 1'b0, 12'h010, 32'h0,        32'h000000DE, 1'b0);
        addVec("ld_bs_011",      1'b0, SZ_B, 1'b1, 12'h011, 32'h0,        32'hFFFFFFAD, 1'b0);
        addVec("ld_hs_012",      1'b0, SZ_H, 1'b1, 12'h012, 32'h0,        32'hFFFFBEEF, 1'b0);
        addVec("ld_hu_012",      1'b0, SZ_H, 1'b0, 12'h012, 32'h0,        32'h0000BEEF, 1'b0);
        addVec("st_b_013",       1'b1, SZ_B, 1'b0, 12'h013, 32'hAABBCC55, 32'h00000000, 1'b0);
        addVec("ld_w_010b",      1'b0, SZ_W, 1'b0, 12'h010, 32'h0,        32'hDEADBE55, 1'b0);
        addVec("ld_ws_010",      1'b0, SZ_W, 1'b1, 12'h010, 32'h0,        32'hDEADBE55, 1'b0);
        addVec("st_w_000",       1'b1, SZ_W, 1'b0, 12'h000, 32'h01234567, 32'h00000000, 1'b0);
        addVec("st_w_002_mis",   1'b1, SZ_W, 1'b0, 12'h002, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        addVec("ld_w_000",       1'b0, SZ_W, 1'b0, 12'h000, 32'h0,        32'h01234567, 1'b0);
        addVec("ld_h_001_mis",   1'b0, SZ_H, 1'b0, 12'h001, 32'h0,        32'h00000000, 1'b1);
        addVec("ld_rsvd_000",    1'b0, SZ_R, 1'b0, 12'h000, 32'h0,        32'h00000000, 1'b1);
        addVec("st_w_004",       1'b1, SZ_W, 1'b0, 12'h004, 32'h11223344, 32'h00000000, 1'b0);
        addVec("st_h_006",       1'b1, SZ_H, 1'b0, 12'h006, 32'hFFFFA1B2, 32'h00000000, 1'b0);
        addVec("st_h_005_mis",   1'b1, SZ_H, 1'b0, 12'h005, 32'h00009999, 32'h00000000, 1'b1);
        addVec("st_rsvd_004",    1'b1, SZ_R, 1'b0, 12'h004, 32'h77777777, 32'h00000000, 1'b1);
        addVec("ld_w_004",       1'b0, SZ_W, 1'b0, 12'h004, 32'h0,        32'h1122A1B2, 1'b0);
        addVec("ld_bs_005_pos",  1'b0, SZ_B, 1'b1, 12'h005, 32'h0,        32'h00000022, 1'b0);
        addVec("st_w_ffc",       1'b1, SZ_W, 1'b0, 12'hFFC, 32'h80000001, 32'h00000000, 1'b0);
        addVec("ld_hs_ffe",      1'b0, SZ_H, 1'b1, 12'hFFE, 32'h0,        32'h00000001, 1'b0);
        addVec("ld_bs_ffc",      1'b0, SZ_B, 1'b1, 12'hFFC, 32'h0,        32'hFFFFFF80, 1'b0);
        addVec("ld_bu_fff",      1'b0, SZ_B, 1'b0, 12'hFFF, 32'h0,        32'h00000001, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Back-pressure: response must hold for 5 cycles while a competing
        // store is offered; the store must not be taken, even on the
        // retiring edge.
        v.name = "stall_ld"; v.write = 1'b0; v.size = SZ_W; v.sgn = 1'b0;
        v.addr = 12'h010; v.wdata = 32'h0; v.exp_rdata = 32'hDEADBE55; v.exp_error = 1'b0;
        issueAndWait(v, cycles);
        checkOutput("stall latency", 32'(cycles), 32'(LATENCY));
        req_write = 1'b1;
        req_size  = SZ_W;
        req_addr  = 12'h010;
        req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall rdata", resp_rdata, 32'hDEADBE55);
            checkOutput("stall resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("stall error", 32'(resp_error), 32'd0);
            checkOutput("stall req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        checkOutput("retire resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("retire req_ready", 32'(req_ready), 32'd1);
        v.name = "post_stall_ld";
        applyStimulus(v);

        // Async reset while a response is held clears the outputs at once.
        v.name = "rst_resp_ld";
        issueAndWait(v, cycles);
        checkOutput("rst_resp pre rdata", resp_rdata, 32'hDEADBE55);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_resp resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_resp req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset in WAIT of a store: outputs clear immediately and the store
        // never reaches memory.
        @(posedge clk);
        #1;
        req_write = 1'b1;
        req_size  = SZ_W;
        req_addr  = 12'h010;
        req_wdata = 32'hCAFEBABE;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("wait_rst in WAIT", 32'(req_ready), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("wait_rst req_ready", 32'(req_ready), 32'd1);
        checkOutput("wait_rst resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("wait_rst resp_rdata", resp_rdata, 32'h0);
        checkOutput("wait_rst resp_error", 32'(resp_error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("wait_rst no resp", 32'(resp_valid), 32'd0);
        v.name = "wait_rst_ld";
        applyStimulus(v);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/byte_memory_unit.md
BYTE_MEMORY_UNIT -- requirements
Module: byte_memory_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, byte-address width; depth = 2**ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter LATENCY, default 1, legal range 1..15, cycles from request accept to response.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, request present.
REQ-006 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 The block SHALL have port req_signed, input, 1, sign-extend on byte/half loads.
REQ-010 The block SHALL have port req_addr, input, ADDR_WIDTH, byte address.
REQ-011 The block SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-012 The block SHALL have port resp_valid, output, 1, response present.
REQ-013 The block SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-014 The block SHALL have port resp_rdata, output, 32, load data, right-aligned and extended.
REQ-015 The block SHALL have port resp_error, output, 1, misaligned or reserved-size request.

Function
REQ-016 The block SHALL use big-endian byte order: byte at addr maps to the most significant byte of the accessed unit.
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-018 When req_valid & req_ready, the block SHALL latch all req_* fields and enter WAIT with the counter loaded to LATENCY-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0 the block SHALL commit the access and enter RESP, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 A store SHALL write only the addressed bytes: byte wdata[7:0]->addr; half wdata[15:8]->addr, [7:0]->addr+1; word [31:24]..[7:0]->addr..addr+3.
REQ-021 A load SHALL return the addressed bytes right-aligned, zero-extended when req_signed = 0 and sign-extended when req_signed = 1; word loads ignore req_signed.
REQ-022 A half access with addr[0] = 1, a word access with addr[1:0] != 0, or size 11 SHALL set resp_error = 1, resp_rdata = 0, and perform no memory write.
REQ-023 A store response SHALL carry resp_rdata = 0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until resp_valid & resp_ready, then the block SHALL return to IDLE.
REQ-025 A new request SHALL NOT be accepted in the same cycle a response retires; minimum issue interval is LATENCY+2 cycles.
REQ-026 A load issued after a completed store SHALL observe the stored data.
REQ-027 Address arithmetic SHALL be confined to aligned accesses, so addr+k never wraps past depth.

Reset
REQ-028 Reset SHALL force IDLE, counter = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0 and resp_error = 0 immediately and asynchronously.
REQ-029 Reset asserted in WAIT SHALL discard the pending access; no partial write SHALL occur.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 A shared package SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state typedef and the alignment-check function.
REQ-032 The byte array and lane steering SHALL live in one sub-module, byte_memory_array, with 4-lane byte-enable write and 4-byte read at a word-aligned index.

Verification
REQ-033 Word store 0xDEADBEEF @0x010, then word load @0x010 -> rdata 0xDEADBEEF, error 0; byte load @0x010 -> 0x000000DE.
REQ-034 Signed byte load @0x011 after the REQ-033 store -> 0xFFFFFFAD; signed half @0x012 -> 0xFFFFBEEF; unsigned half @0x012 -> 0x0000BEEF.
REQ-035 Byte store 0x55 @0x013, then word load @0x010 -> 0xDEADBE55.
REQ-036 Word store @0x002 -> resp_error 1, rdata 0; subsequent word load @0x000 is unchanged.
REQ-037 With LATENCY = 3, resp_valid rises 3 cycles after accept; holding resp_ready = 0 for 5 cycles keeps the response stable and req_ready = 0.
REQ-038 Reset asserted in WAIT of a store -> outputs cleared at once and the target word unchanged on the next load.
